// File: rtl/chip8_key_ctrl.sv
// rtl/chip8_key_ctrl.sv - CHIP-8 keypad debouncer and key-command sequencer
//
// Ports:
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   keys_raw[15:0]        raw key levels, 1 = pressed
//   cmd_valid/cmd_ready   command handshake; cmd_op 0=SKP 1=SKNP 2=WAITKEY 3=reserved
//   cmd_key[3:0]          key index for SKP/SKNP
//   abort                 cancels a pending WAITKEY
//   rsp_valid/rsp_ready   response handshake; rsp_skip, rsp_key, rsp_err payload
//   busy                  WAITKEY in progress
//   key_db[15:0]          debounced key state
module chip8_key_ctrl #(
  parameter int  DEBOUNCE_CYCLES = 16,
  localparam int CW              = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] keys_raw,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_key,
  input  logic        abort,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_skip,
  output logic [3:0]  rsp_key,
  output logic        rsp_err,
  output logic        busy,
  output logic [15:0] key_db
);

  localparam logic [1:0] OP_SKP  = 2'd0;
  localparam logic [1:0] OP_SKNP = 2'd1;
  localparam logic [1:0] OP_WAIT = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE,
    RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt [16];
  logic [15:0]   mask;
  logic [3:0]    sel;
  logic [15:0]   new_keys;

  // Keys pressed since the wait began; held-at-issue keys stay masked until
  // they have been seen released at least once.
  assign new_keys = key_db & ~mask;

  function automatic logic [3:0] lowest_index(input logic [15:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

  // Per-key debounce: the counter tracks how long the raw level has disagreed
  // with the debounced level. The flip happens on the edge where the counter
  // already sits at DEBOUNCE_CYCLES-1, so a stable change takes exactly
  // DEBOUNCE_CYCLES edges to appear on key_db.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_db <= '0;
      for (int i = 0; i < 16; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (keys_raw[i] == key_db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i]    <= '0;
          key_db[i] <= ~key_db[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Command sequencer. All outputs are registered here; cmd_ready mirrors
  // "state == IDLE" one edge ahead so it is valid for the whole IDLE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_skip  <= 1'b0;
      rsp_key   <= 4'd0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      mask      <= '0;
      sel       <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            case (cmd_op)
              OP_SKP, OP_SKNP: begin
                rsp_skip  <= key_db[cmd_key] ^ (cmd_op == OP_SKNP);
                rsp_key   <= 4'd0;
                rsp_err   <= 1'b0;
                rsp_valid <= 1'b1;
                state     <= RESP;
              end
              OP_WAIT: begin
                mask  <= key_db;
                busy  <= 1'b1;
                state <= WAIT_PRESS;
              end
              default: begin
                rsp_skip  <= 1'b0;
                rsp_key   <= 4'd0;
                rsp_err   <= 1'b1;
                rsp_valid <= 1'b1;
                state     <= RESP;
              end
            endcase
          end
        end

        WAIT_PRESS: begin
          // abort takes priority over a press seen on the same edge
          if (abort) begin
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            mask <= mask & key_db;
            if (new_keys != 16'd0) begin
              sel   <= lowest_index(new_keys);
              state <= WAIT_RELEASE;
            end
          end
        end

        WAIT_RELEASE: begin
          if (abort) begin
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end else if (!key_db[sel]) begin
            rsp_key   <= sel;
            rsp_skip  <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= RESP;
          end
        end

        RESP: begin
          // Payload is left untouched so it stays stable until the handshake.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_key_ctrl.sv
// tb/tb_chip8_key_ctrl.sv - scoreboard bench for chip8_key_ctrl
module tb_chip8_key_ctrl;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] keys_raw = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [3:0]  cmd_key = 4'd0;
  logic        abort = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_skip;
  logic [3:0]  rsp_key;
  logic        rsp_err;
  logic        busy;
  logic [15:0] key_db;

  chip8_key_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .keys_raw  (keys_raw),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_key   (cmd_key),
    .abort     (abort),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_skip  (rsp_skip),
    .rsp_key   (rsp_key),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .key_db    (key_db)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  bit rand_done = 1'b0;

  typedef struct packed {
    logic       skip;
    logic [3:0] key;
    logic       err;
  } rsp_t;

  rsp_t exp_q[$];

  // Reference model state
  bit          m_wait, m_rel, m_resp;
  logic [15:0] m_db, m_mask, m_fresh;
  logic [3:0]  m_sel;
  int          cyc = 0;
  int          last_agree[16];

  function automatic rsp_t mk(input logic s, input logic [3:0] k, input logic e);
    rsp_t r;
    r.skip = s;
    r.key  = k;
    r.err  = e;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h time=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timed out time=%0t", nm, $time);
  endtask

  // Model: uses the debounced view from before this edge, then advances the
  // debounce by timestamps (a key flips once raw has disagreed for D samples).
  always @(posedge clk) begin
    cyc++;
    if (!reset_n) begin
      m_wait = 0; m_rel = 0; m_resp = 0;
      m_db = '0; m_mask = '0; m_sel = '0;
      exp_q.delete();
      for (int i = 0; i < 16; i++) last_agree[i] = cyc;
    end else begin
      if (m_wait) begin
        if (abort) begin
          m_wait = 0;
        end else if (!m_rel) begin
          m_fresh = m_db & ~m_mask;
          for (int i = 0; i < 16; i++) begin
            if (m_fresh[i]) begin
              m_sel = 4'(i);
              m_rel = 1;
              break;
            end
          end
          m_mask = m_mask & m_db;
        end else if (!m_db[m_sel]) begin
          exp_q.push_back(mk(1'b0, m_sel, 1'b0));
          m_resp = 1;
          m_wait = 0;
        end
      end else if (m_resp) begin
        if (rsp_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          m_resp = 0;
        end
      end else if (cmd_valid) begin
        case (cmd_op)
          2'd0: begin exp_q.push_back(mk(m_db[cmd_key], 4'd0, 1'b0)); m_resp = 1; end
          2'd1: begin exp_q.push_back(mk(!m_db[cmd_key], 4'd0, 1'b0)); m_resp = 1; end
          2'd2: begin m_wait = 1; m_rel = 0; m_mask = m_db; end
          default: begin exp_q.push_back(mk(1'b0, 4'd0, 1'b1)); m_resp = 1; end
        endcase
      end
      for (int i = 0; i < 16; i++) begin
        if (keys_raw[i] == m_db[i]) last_agree[i] = cyc;
        else if (cyc - last_agree[i] >= D) begin
          m_db[i] = ~m_db[i];
          last_agree[i] = cyc;
        end
      end
    end
  end

  // Monitor: compares DUT outputs with the model/scoreboard after each edge.
  always @(posedge clk) begin
    #1;
    if (reset_n && mon_en) begin
      chk("key_db", key_db, m_db);
      chk("busy", 16'(busy), 16'(m_wait));
      chk("cmd_ready", 16'(cmd_ready), 16'(!m_wait && !m_resp));
      chk("rsp_valid", 16'(rsp_valid), 16'(m_resp));
      if (m_resp && rsp_valid && exp_q.size() > 0) begin
        chk("rsp_skip", 16'(rsp_skip), 16'(exp_q[0].skip));
        chk("rsp_key", 16'(rsp_key), 16'(exp_q[0].key));
        chk("rsp_err", 16'(rsp_err), 16'(exp_q[0].err));
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [3:0] k);
    int n;
    n = 0;
    @(negedge clk);
    cmd_op = op;
    cmd_key = k;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) timeout("issue");
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_db(input int idx, input logic val, input string nm);
    int n;
    n = 0;
    while (key_db[idx] !== val && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeout(nm);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_cmd_ready"}, 16'(cmd_ready), 16'd1);
    chk({nm, "_rsp_valid"}, 16'(rsp_valid), 16'd0);
    chk({nm, "_rsp_skip"}, 16'(rsp_skip), 16'd0);
    chk({nm, "_rsp_key"}, 16'(rsp_key), 16'd0);
    chk({nm, "_rsp_err"}, 16'(rsp_err), 16'd0);
    chk({nm, "_busy"}, 16'(busy), 16'd0);
    chk({nm, "_key_db"}, key_db, 16'd0);
  endtask

  initial begin
    int n;
    int idx;
    repeat (2) @(negedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    reset_n = 1'b1;
    mon_en = 1'b1;

    // glitch of D-1 cycles is filtered
    @(negedge clk); keys_raw[5] = 1'b1;
    repeat (3) @(negedge clk);
    keys_raw[5] = 1'b0;
    chk("glitch_db5", 16'(key_db[5]), 16'd0);
    repeat (3) @(negedge clk);
    chk("glitch_db5_after", 16'(key_db[5]), 16'd0);

    // stable press appears after exactly D cycles
    keys_raw[5] = 1'b1;
    repeat (3) @(negedge clk);
    chk("lat_minus1", 16'(key_db[5]), 16'd0);
    @(negedge clk);
    chk("lat_exact", 16'(key_db[5]), 16'd1);

    // skip queries with key_db = 0x0020
    issue(2'd0, 4'd5);
    chk("skp5_valid", 16'(rsp_valid), 16'd1);
    chk("skp5_skip", 16'(rsp_skip), 16'd1);
    issue(2'd1, 4'd5);
    chk("sknp5_skip", 16'(rsp_skip), 16'd0);
    issue(2'd0, 4'd3);
    chk("skp3_skip", 16'(rsp_skip), 16'd0);

    // WAITKEY with key 2 held, then 9 and 4 together, lowest wins
    @(negedge clk); keys_raw = 16'h0004;
    repeat (6) @(negedge clk);
    chk("held2_db", key_db, 16'h0004);
    issue(2'd2, 4'd0);
    repeat (3) @(negedge clk);
    keys_raw = 16'h0000;
    repeat (6) @(negedge clk);
    keys_raw = 16'h0210;
    repeat (8) @(negedge clk);
    chk("wait_no_rsp_while_held", 16'(rsp_valid), 16'd0);
    keys_raw = 16'h0200;
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout("waitkey_rsp");
    chk("waitkey_key", 16'(rsp_key), 16'd4);
    chk("waitkey_busy", 16'(busy), 16'd0);
    @(negedge clk); keys_raw = '0;
    repeat (6) @(negedge clk);

    // abort on the same edge the release is seen
    issue(2'd2, 4'd0);
    keys_raw = 16'h0080;
    wait_db(7, 1'b1, "abort_press");
    keys_raw = 16'h0000;
    wait_db(7, 1'b0, "abort_release");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("abort_cmd_ready", 16'(cmd_ready), 16'd1);
    chk("abort_busy", 16'(busy), 16'd0);
    repeat (3) @(negedge clk);
    chk("abort_no_late_rsp", 16'(rsp_valid), 16'd0);

    // response held under backpressure while keys move
    rsp_ready = 1'b0;
    issue(2'd1, 4'd7);
    for (int i = 0; i < 10; i++) begin
      keys_raw = 16'($urandom);
      @(negedge clk);
    end
    chk("stall_cmd_ready", 16'(cmd_ready), 16'd0);
    chk("stall_skip", 16'(rsp_skip), 16'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_hs_cmd_ready", 16'(cmd_ready), 16'd1);
    chk("post_hs_rsp_valid", 16'(rsp_valid), 16'd0);
    keys_raw = '0;
    repeat (6) @(negedge clk);

    // reset in the middle of WAIT_RELEASE
    issue(2'd2, 4'd0);
    keys_raw = 16'h0002;
    wait_db(1, 1'b1, "rst_press");
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    keys_raw = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    issue(2'd3, 4'd9);
    chk("op3_err", 16'(rsp_err), 16'd1);
    chk("op3_skip", 16'(rsp_skip), 16'd0);

    // randomized traffic
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          issue(2'($urandom_range(0, 3)), 4'($urandom));
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          if ($urandom_range(0, 7) == 0) begin
            idx = $urandom_range(0, 15);
            keys_raw[idx] = ~keys_raw[idx];
          end
          abort = ($urandom_range(0, 29) == 0);
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join

    abort = 1'b0;
    rsp_ready = 1'b1;
    keys_raw = '0;
    repeat (20) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
